// File: rtl/decode_stage.sv
// Decode stage: registers fetch output, cracks fields/strobes/immediate,
// and sequences LM/SM into one micro-op per selected register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] irf,
    input  logic [15:0] pc_fetch,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        fetch_hold,
    output logic        id_valid,
    output logic [15:0] id_pc,
    output logic [3:0]  id_opcode,
    output logic [2:0]  id_ra,
    output logic [2:0]  id_rb,
    output logic [2:0]  id_rc,
    output logic [15:0] id_imm,
    output logic        id_rf_we,
    output logic        id_mem_rd,
    output logic        id_mem_wr,
    output logic        id_illegal,
    output logic [2:0]  id_dest
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_LM   = 4'b0110;
    localparam logic [3:0] OP_SM   = 4'b0111;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JLR  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1100;

    typedef enum logic {IDLE, MULTI} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  src_mask, rest_mask;
    logic [2:0]  sel_idx;

    logic        fh_d, valid_d, we_d, rd_d, wr_d, ill_d;
    logic [15:0] pc_d, imm_d;
    logic [3:0]  opc_d;
    logic [2:0]  ra_d, rb_d, rc_d, dest_d;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        valid_d  = id_valid;
        pc_d     = id_pc;
        opc_d    = id_opcode;
        ra_d     = id_ra;
        rb_d     = id_rb;
        rc_d     = id_rc;
        imm_d    = id_imm;
        we_d     = id_rf_we;
        rd_d     = id_mem_rd;
        wr_d     = id_mem_wr;
        ill_d    = id_illegal;
        dest_d   = id_dest;

        // Lowest set bit of the active mask picks the next LM/SM register
        src_mask  = (state_q == MULTI) ? mask_q : irf[7:0];
        sel_idx   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (src_mask[i]) sel_idx = 3'(i);
        end
        rest_mask = src_mask & (src_mask - 8'd1);

        if (flush) begin
            state_d = IDLE;
            mask_d  = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ill_d   = 1'b0;
        end else if (stall) begin
            state_d = state_q;
        end else if (state_q == MULTI) begin
            valid_d = 1'b1;
            rc_d    = sel_idx;
            imm_d   = 16'(cnt_q);
            we_d    = (id_opcode == OP_LM);
            rd_d    = (id_opcode == OP_LM);
            wr_d    = (id_opcode == OP_SM);
            ill_d   = 1'b0;
            dest_d  = (id_opcode == OP_LM) ? sel_idx : 3'd0;
            mask_d  = rest_mask;
            cnt_d   = cnt_q + 3'd1;
            if (rest_mask == 8'd0) state_d = IDLE;
        end else if (if_valid) begin
            valid_d = 1'b1;
            pc_d    = pc_fetch;
            opc_d   = irf[15:12];
            ra_d    = irf[11:9];
            rb_d    = irf[8:6];
            rc_d    = irf[5:3];
            imm_d   = '0;
            we_d    = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ill_d   = 1'b0;
            dest_d  = '0;
            unique case (irf[15:12])
                OP_ADD, OP_NAND: begin we_d = 1'b1; dest_d = irf[5:3]; end
                OP_ADI: begin
                    imm_d = {{10{irf[5]}}, irf[5:0]};
                    we_d  = 1'b1;
                    dest_d = irf[8:6];
                end
                OP_LHI: begin imm_d = {irf[8:0], 7'b0}; we_d = 1'b1; dest_d = irf[11:9]; end
                OP_LW: begin
                    imm_d  = {{10{irf[5]}}, irf[5:0]};
                    we_d   = 1'b1;
                    rd_d   = 1'b1;
                    dest_d = irf[11:9];
                end
                OP_SW: begin imm_d = {{10{irf[5]}}, irf[5:0]}; wr_d = 1'b1; end
                OP_BEQ: imm_d = {{10{irf[5]}}, irf[5:0]};
                OP_JAL: begin imm_d = {{7{irf[8]}}, irf[8:0]}; we_d = 1'b1; dest_d = irf[11:9]; end
                OP_JLR: begin we_d = 1'b1; dest_d = irf[11:9]; end
                OP_LM, OP_SM: begin
                    // Empty mask decodes as a NOP with every strobe low
                    if (irf[7:0] != 8'd0) begin
                        rc_d = sel_idx;
                        we_d = (irf[15:12] == OP_LM);
                        rd_d = (irf[15:12] == OP_LM);
                        wr_d = (irf[15:12] == OP_SM);
                        dest_d = (irf[15:12] == OP_LM) ? sel_idx : 3'd0;
                        if (rest_mask != 8'd0) begin
                            state_d = MULTI;
                            mask_d  = rest_mask;
                            cnt_d   = 3'd1;
                        end
                    end
                end
                default: ill_d = 1'b1;
            endcase
        end else begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ill_d   = 1'b0;
        end

        fh_d = (state_d == MULTI);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cnt_q      <= '0;
            fetch_hold <= 1'b0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_opcode  <= '0;
            id_ra      <= '0;
            id_rb      <= '0;
            id_rc      <= '0;
            id_imm     <= '0;
            id_rf_we   <= 1'b0;
            id_mem_rd  <= 1'b0;
            id_mem_wr  <= 1'b0;
            id_illegal <= 1'b0;
            id_dest    <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            fetch_hold <= fh_d;
            id_valid   <= valid_d;
            id_pc      <= pc_d;
            id_opcode  <= opc_d;
            id_ra      <= ra_d;
            id_rb      <= rb_d;
            id_rc      <= rc_d;
            id_imm     <= imm_d;
            id_rf_we   <= we_d;
            id_mem_rd  <= rd_d;
            id_mem_wr  <= wr_d;
            id_illegal <= ill_d;
            id_dest    <= dest_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: random instructions and LM/SM
// sequences compared against a behavioural decode/expansion model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] irf;
    logic [15:0] pc_fetch;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic        fetch_hold;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [3:0]  id_opcode;
    logic [2:0]  id_ra, id_rb, id_rc;
    logic [15:0] id_imm;
    logic        id_rf_we, id_mem_rd, id_mem_wr, id_illegal;
    logic [2:0]  id_dest;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [3:0]  opc;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rc;
        logic [15:0] imm;
        logic        we;
        logic        rd;
        logic        wr;
        logic        ill;
        logic [2:0]  dest;
    } op_t;

    op_t obs;
    op_t exp_q[$];

    assign obs = {id_valid, id_pc, id_opcode, id_ra, id_rb, id_rc, id_imm,
                  id_rf_we, id_mem_rd, id_mem_wr, id_illegal, id_dest};

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .irf        (irf),
        .pc_fetch   (pc_fetch),
        .if_valid   (if_valid),
        .stall      (stall),
        .flush      (flush),
        .fetch_hold (fetch_hold),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_opcode  (id_opcode),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_rc      (id_rc),
        .id_imm     (id_imm),
        .id_rf_we   (id_rf_we),
        .id_mem_rd  (id_mem_rd),
        .id_mem_wr  (id_mem_wr),
        .id_illegal (id_illegal),
        .id_dest    (id_dest)
    );

    always #5 clk = ~clk;

    // ISA table: what a single non-sequenced instruction decodes to
    function automatic op_t model_single(input logic [15:0] ir, input logic [15:0] pc);
        op_t o;
        o       = '0;
        o.valid = 1'b1;
        o.pc    = pc;
        o.opc   = ir[15:12];
        o.ra    = ir[11:9];
        o.rb    = ir[8:6];
        o.rc    = ir[5:3];
        case (ir[15:12])
            4'h0, 4'h2: begin o.we = 1'b1; o.dest = ir[5:3]; end
            4'h1: begin o.imm = 16'($signed(ir[5:0])); o.we = 1'b1; o.dest = ir[8:6]; end
            4'h3: begin o.imm = 16'(ir[8:0]) << 7; o.we = 1'b1; o.dest = ir[11:9]; end
            4'h4: begin o.imm = 16'($signed(ir[5:0])); o.we = 1'b1; o.rd = 1'b1; o.dest = ir[11:9]; end
            4'h5: begin o.imm = 16'($signed(ir[5:0])); o.wr = 1'b1; end
            4'hC: o.imm = 16'($signed(ir[5:0]));
            4'h8: begin o.imm = 16'($signed(ir[8:0])); o.we = 1'b1; o.dest = ir[11:9]; end
            4'h9: begin o.we = 1'b1; o.dest = ir[11:9]; end
            4'h6, 4'h7: o.imm = 16'd0;
            default: o.ill = 1'b1;
        endcase
        return o;
    endfunction

    // Expand an LM/SM into its micro-op list (mask 0 yields one NOP)
    function automatic void expand(input logic [15:0] ir, input logic [15:0] pc);
        op_t o;
        int  n;
        n = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (ir[i]) begin
                o       = '0;
                o.valid = 1'b1;
                o.pc    = pc;
                o.opc   = ir[15:12];
                o.ra    = ir[11:9];
                o.rb    = ir[8:6];
                o.rc    = 3'(i);
                o.imm   = 16'(n);
                if (ir[15:12] == 4'h6) begin
                    o.we = 1'b1; o.rd = 1'b1; o.dest = 3'(i);
                end else begin
                    o.wr = 1'b1;
                end
                exp_q.push_back(o);
                n++;
            end
        end
        if (exp_q.size() == 0) exp_q.push_back(model_single(ir, pc));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op_t e;
        reset = 1'b1; irf = 16'h1FFF; pc_fetch = 16'h0040;
        if_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0 || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %h fh=%b expected 0 fh=0", obs, fetch_hold);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        e = model_single(16'h1FFF, 16'h0040);
        checks++;
        if (obs !== e || e.imm !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_first_adi: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_single_random();
        logic [15:0] ir, pc;
        op_t e;
        // directed LHI and illegal opcode first
        irf = 16'h31FF; pc_fetch = 16'h1000; if_valid = 1'b1;
        step();
        e = model_single(16'h31FF, 16'h1000);
        checks++;
        if (obs !== e || id_imm !== 16'hFF80 || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL lhi: got %h expected %h", obs, e);
        end
        irf = 16'hF123;
        step();
        e = model_single(16'hF123, 16'h1000);
        checks++;
        if (obs !== e || id_illegal !== 1'b1 || id_valid !== 1'b1) begin
            failures++;
            $display("FAIL illegal: got %h expected %h", obs, e);
        end
        for (int t = 0; t < 60; t++) begin
            ir = 16'($urandom);
            if (ir[15:12] == 4'h6 || ir[15:12] == 4'h7) ir[15] = 1'b1;
            pc = 16'($urandom);
            irf = ir; pc_fetch = pc;
            if_valid = ($urandom_range(0, 7) != 0);
            step();
            checks++;
            if (if_valid) begin
                e = model_single(ir, pc);
                if (obs !== e || fetch_hold !== 1'b0) begin
                    failures++;
                    $display("FAIL single_rand ir=%h: got %h expected %h", ir, obs, e);
                end
            end else if (id_valid !== 1'b0) begin
                failures++;
                $display("FAIL bubble: id_valid got %b expected 0", id_valid);
            end
        end
        if_valid = 1'b1;
    endtask

    task automatic test_lm_directed();
        expand(16'h6A25, 16'h2000);
        irf = 16'h6A25; pc_fetch = 16'h2000; if_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            irf = 16'h0ABC;
            pc_fetch = 16'h3333;
            checks++;
            if (obs !== exp_q[c] || fetch_hold !== (c < 2)) begin
                failures++;
                $display("FAIL lm_uop%0d: got %h fh=%b expected %h fh=%b",
                         c, obs, fetch_hold, exp_q[c], (c < 2));
            end
        end
    endtask

    task automatic test_sm_stall();
        int e;
        op_t held;
        expand(16'h74FF, 16'h4444);
        irf = 16'h74FF; pc_fetch = 16'h4444; if_valid = 1'b1; stall = 1'b0;
        e = 0;
        for (int c = 0; c < 10; c++) begin
            stall = (c == 3 || c == 4);
            step();
            irf = 16'($urandom);
            if (c > 0 && !stall) e++;
            checks++;
            if (obs !== exp_q[e] || fetch_hold !== (e < 7)) begin
                failures++;
                $display("FAIL sm_stall c=%0d: got %h fh=%b expected %h fh=%b",
                         c, obs, fetch_hold, exp_q[e], (e < 7));
            end
        end
        held = exp_q[7];
        stall = 1'b0;
        checks++;
        if (held.imm !== 16'd7) begin
            failures++;
            $display("FAIL sm_last_offset: got %h expected 7", held.imm);
        end
    endtask

    task automatic test_flush();
        op_t e;
        expand(16'h660F, 16'h5000);
        irf = 16'h660F; pc_fetch = 16'h5000; if_valid = 1'b1;
        step();
        step();
        checks++;
        if (obs !== exp_q[1] || fetch_hold !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre: got %h fh=%b expected %h fh=1", obs, fetch_hold, exp_q[1]);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL flush_kill: valid=%b fh=%b expected 0 0", id_valid, fetch_hold);
        end
        irf = 16'h029C; pc_fetch = 16'h5002;
        step();
        e = model_single(16'h029C, 16'h5002);
        checks++;
        if (obs !== e || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL flush_next_add: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_stall_flush();
        op_t e;
        irf = 16'h1A4B; pc_fetch = 16'h6000; if_valid = 1'b1;
        step();
        e = model_single(16'h1A4B, 16'h6000);
        stall = 1'b1; irf = 16'h4C01; pc_fetch = 16'h6002;
        step();
        step();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL stall_hold: got %h expected %h", obs, e);
        end
        flush = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL stall_flush: valid=%b fh=%b expected 0 0", id_valid, fetch_hold);
        end
    endtask

    task automatic test_reset_multi();
        irf = 16'h70FF; pc_fetch = 16'h7000; if_valid = 1'b1;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0 || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL reset_multi: got %h fh=%b expected 0", obs, fetch_hold);
        end
        @(negedge clk);
        reset = 1'b1; if_valid = 1'b0;
        step();
        step();
        checks++;
        if (id_valid !== 1'b0 || fetch_hold !== 1'b0) begin
            failures++;
            $display("FAIL reset_multi_abandon: valid=%b fh=%b expected 0 0", id_valid, fetch_hold);
        end
        if_valid = 1'b1;
    endtask

    task automatic test_random_multi();
        logic [15:0] ir, pc;
        logic [7:0]  mask;
        int k, e, guard, sel;
        for (int t = 0; t < 16; t++) begin
            sel = $urandom_range(0, 5);
            mask = 8'($urandom);
            if (sel == 0) mask = 8'd0;
            else if (sel == 1) mask = 8'd1 << $urandom_range(0, 7);
            ir = {3'b011, 1'($urandom), 3'($urandom), 1'($urandom), mask};
            pc = 16'($urandom);
            expand(ir, pc);
            k = exp_q.size();
            irf = ir; pc_fetch = pc; if_valid = 1'b1; stall = 1'b0;
            step();
            e = 0;
            checks++;
            if (obs !== exp_q[0] || fetch_hold !== (k > 1)) begin
                failures++;
                $display("FAIL multi_rand ir=%h uop0: got %h fh=%b expected %h", ir, obs, fetch_hold, exp_q[0]);
            end
            guard = 0;
            while (e < k - 1 && guard < 64) begin
                stall = ($urandom_range(0, 2) == 0);
                irf = 16'($urandom);
                step();
                if (!stall) e++;
                guard++;
                checks++;
                if (obs !== exp_q[e] || fetch_hold !== (e < k - 1)) begin
                    failures++;
                    $display("FAIL multi_rand ir=%h uop%0d: got %h fh=%b expected %h",
                             ir, e, obs, fetch_hold, exp_q[e]);
                end
            end
            stall = 1'b0;
            if (e < k - 1) begin
                failures++;
                $display("FAIL multi_timeout ir=%h: emitted %0d expected %0d", ir, e + 1, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_random();
        test_lm_directed();
        test_sm_stall();
        test_flush();
        test_stall_flush();
        test_reset_multi();
        test_random_multi();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the 6-stage 16-bit pipeline. It registers the instruction word and PC coming from fetch, cracks the instruction into fields, control strobes and an extended immediate, and hands the result to register-read. It also sequences load-multiple/store-multiple (LM/SM) instructions into one micro-op per selected register, holding fetch while it does so.

## Interface
Parameters:
- none (16-bit datapath, 8 architectural registers, fixed ISA)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- irf  in  16  instruction word from fetch
- pc_fetch  in  16  PC of irf
- if_valid  in  1  irf/pc_fetch hold a real instruction
- stall  in  1  downstream hazard stall; hold all outputs and state
- flush  in  1  branch/jump redirect; kill the instruction in this stage
- fetch_hold  out  1  fetch must not advance the PC (LM/SM sequencing)
- id_valid  out  1  outputs carry a live (micro-)op
- id_pc  out  16  PC of the op
- id_opcode  out  4  irf[15:12]
- id_ra, id_rb, id_rc  out  3 each  irf[11:9], irf[8:6], irf[5:3]; for an LM/SM micro-op, id_rc is the selected register
- id_imm  out  16  extended immediate or LM/SM offset
- id_rf_we, id_mem_rd, id_mem_wr, id_illegal  out  1 each  control strobes
- id_dest  out  3  write-back register

## Operation
- Opcodes: 0000 ADD, 0010 NAND, 0001 ADI, 0011 LHI, 0100 LW, 0101 SW, 0110 LM, 0111 SM, 1100 BEQ, 1000 JAL, 1001 JLR. Any other opcode is illegal.
- Immediates:
  - ADI, LW, SW, BEQ: sign-extend irf[5:0].
  - LHI: {irf[8:0], 7'b0}.
  - JAL: sign-extend irf[8:0].
  - All others: 0.
- Destination and control:
  - ADD, NAND: id_dest = rc, rf_we = 1.
  - ADI: id_dest = rb, rf_we = 1.
  - LHI, LW, JAL, JLR: id_dest = ra, rf_we = 1.
  - LW: mem_rd = 1. SW: mem_wr = 1.
  - BEQ, SW: rf_we = 0.
- Illegal opcode: id_valid = 1, id_illegal = 1, all other strobes 0.
- LM/SM: irf[7:0] is the register mask and RA is the base.
  - Set bits are emitted lowest index first, one micro-op each.
  - Per micro-op: id_rc = bit index, id_imm = count of set bits already emitted (0..7, zero-extended), id_opcode unchanged, ra = base.
  - LM micro-op: mem_rd = 1, rf_we = 1, id_dest = bit index.
  - SM micro-op: mem_wr = 1, rf_we = 0.
  - On acceptance the remaining mask, base, PC and opcode are latched internally. irf is ignored until the sequence ends.
  - Mask 0: one op with id_valid = 1 and all strobes 0 (architectural NOP).
- Sequencer states:
  - IDLE → MULTI when an LM/SM with ≥2 set bits is accepted.
  - MULTI → IDLE after the last micro-op is emitted, or on flush.
  - fetch_hold = (state == MULTI), driven from a register.

## Timing
- Reset: every output is 0, state is IDLE, internal mask is 0. Reset takes effect immediately regardless of clk.
- Latency: an instruction accepted at edge N appears on the outputs after edge N. Accept means if_valid=1, stall=0, flush=0, state=IDLE.
- if_valid=0 in IDLE with no stall: id_valid becomes 0 at the next edge.
- stall=1: all outputs, state and mask hold; no micro-op is consumed.
- flush=1: at the next edge id_valid = 0, state = IDLE, mask is cleared and fetch_hold = 0. flush has priority over stall.
- LM/SM with k set bits accepted at edge N:
  - Micro-ops appear after edges N..N+k-1 when there are no stalls.
  - fetch_hold is high after edges N..N+k-2, i.e. for k-1 cycles.
  - Each stall cycle extends both windows by one.
- k=1: single op, fetch_hold stays 0, state stays IDLE.
- Reset during MULTI: the sequence is abandoned and no further micro-ops are emitted.

## Test plan
- Reset with irf=16'h1FFF, if_valid=1, reset low → all outputs 0. After release and one edge: ADI, ra=7, rb=7, id_imm=16'hFFFF, id_dest=7, rf_we=1.
- LHI irf=16'h31FF → id_imm=16'hFF80, id_dest=0, rf_we=1. Opcode 1111 → id_illegal=1, id_valid=1, strobes 0.
- LM irf=16'h6A25 (base 5, mask 0010_0101) → micro-ops rc=0/imm=0, rc=2/imm=1, rc=5/imm=2 on three consecutive cycles, each with rf_we=1, mem_rd=1. fetch_hold is high for the first two cycles. A different irf applied meanwhile is ignored.
- SM with mask 8'hFF and stall=1 during the 3rd micro-op for 2 cycles → 8 micro-ops over 10 cycles, offsets 0..7. The held outputs do not change while stalled.
- flush during the 2nd micro-op of an LM with mask 8'h0F → next cycle id_valid=0, fetch_hold=0. The following ADD is decoded normally.
- stall=1 and flush=1 together → flush wins: id_valid=0.
